// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter.
//   rx_state_t    : receiver FSM state encoding
//   DEFAULT_*     : default baud/frame constants, also used by the transmitter
//   half_bit()    : clock count from the start-bit edge to the middle of the bit
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLOCKS_PER_BIT      = 434;
  localparam int DEFAULT_DATA_WIDTH          = 8;
  localparam int DEFAULT_CLOCK_COUNTER_WIDTH = 10;
  localparam int DEFAULT_BIT_COUNTER_WIDTH   = 3;

  // Integer division: an odd bit period samples slightly before the true centre.
  function automatic int half_bit(input int clocks_per_bit);
    return clocks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_shift_datapath.sv
// -----------------------------------------------------------------------------
// uart_rx_shift_datapath
// Receive shift register, output byte register and handshake/overrun flags.
//   i_clock   : system clock, rising edge
//   i_reset   : synchronous active-high reset
//   i_shift   : one-cycle strobe, shift i_rx_bit into the shift register
//   i_load    : one-cycle strobe, a good frame completed; publish the byte
//   i_rx_bit  : synchronised RX line
//   i_ack     : consumer accepts o_data (ignored while o_valid=0)
//   o_data    : last good received byte
//   o_valid   : o_data holds an unacknowledged byte
//   o_overrun : sticky, a byte was overwritten before it was acknowledged
// -----------------------------------------------------------------------------
module uart_rx_shift_datapath
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_shift,
  input  logic                  i_load,
  input  logic                  i_rx_bit,
  input  logic                  i_ack,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun
);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;

  // Shift register: bits enter at the MSB, so the first bit received ends in bit 0
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift <= {DATA_WIDTH{1'b0}};
    end else if (i_shift) begin
      r_shift <= {i_rx_bit, r_shift[DATA_WIDTH-1:1]};
    end else begin
      r_shift <= r_shift;
    end
  end

  // Output byte with valid/ack handshake and sticky overrun
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data    <= {DATA_WIDTH{1'b0}};
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_load) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
      // An ack in the load cycle consumes the old byte, so nothing is lost.
      if (r_valid && !i_ack) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_ack) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end else if (r_valid && i_ack) begin
      r_data    <= r_data;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_data    <= r_data;
      r_valid   <= r_valid;
      r_overrun <= r_overrun;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_control_unit.sv
// -----------------------------------------------------------------------------
// uart_rx_control_unit
// UART receiver: RX synchroniser, frame sequencing FSM and counters; the byte
// datapath lives in uart_rx_shift_datapath.
//   i_clock         : system clock, rising edge
//   i_reset         : synchronous active-high reset
//   i_RX            : asynchronous serial line, idles high
//   i_ack           : consumer accepts o_data
//   o_data          : last good received byte
//   o_valid         : o_data holds an unacknowledged byte
//   o_framing_error : one-cycle pulse when a stop bit is sampled low
//   o_overrun       : sticky, a byte was overwritten before it was acked
//   o_busy          : FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_control_unit
  import uart_pkg::*;
#(
  parameter int CLOCK_COUNTER_WIDTH = DEFAULT_CLOCK_COUNTER_WIDTH,
  parameter int BIT_COUNTER_WIDTH   = DEFAULT_BIT_COUNTER_WIDTH,
  parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  parameter int CLOCKS_PER_BIT      = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_RX,
  input  logic                  i_ack,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_framing_error,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int HALF = half_bit(CLOCKS_PER_BIT);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] C_CLK_ZERO     = {CLOCK_COUNTER_WIDTH{1'b0}};
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] C_CLK_ONE      = {{(CLOCK_COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] C_HALF_LAST    = CLOCK_COUNTER_WIDTH'(HALF - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] C_BIT_LAST     = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0]   C_BIT_ZERO     = {BIT_COUNTER_WIDTH{1'b0}};
  localparam logic [BIT_COUNTER_WIDTH-1:0]   C_BIT_ONE      = {{(BIT_COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIT_COUNTER_WIDTH-1:0]   C_LAST_DATA    = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  logic                           r_rx_meta;
  logic                           r_rx_sync;
  rx_state_t                      r_state;
  rx_state_t                      w_state_next;
  logic [CLOCK_COUNTER_WIDTH-1:0] r_clk_cnt;
  logic [CLOCK_COUNTER_WIDTH-1:0] w_clk_cnt_next;
  logic [BIT_COUNTER_WIDTH-1:0]   r_bit_cnt;
  logic [BIT_COUNTER_WIDTH-1:0]   w_bit_cnt_next;
  logic                           w_shift;
  logic                           w_load;
  logic                           w_framing_error;
  logic                           r_framing_error;
  logic                           r_busy;

  // Two-flop synchroniser; flops reset to the idle line level
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Next-state, counter and strobe logic; every decision point restarts clk_cnt
  always_comb begin
    w_state_next    = r_state;
    w_clk_cnt_next  = r_clk_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift         = 1'b0;
    w_load          = 1'b0;
    w_framing_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_next = C_CLK_ZERO;
        w_bit_cnt_next = C_BIT_ZERO;
        if (!r_rx_sync) begin
          w_state_next = ST_START;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch.
        if (r_clk_cnt == C_HALF_LAST) begin
          w_clk_cnt_next = C_CLK_ZERO;
          if (!r_rx_sync) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + C_CLK_ONE;
        end
      end
      ST_DATA: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_next = C_CLK_ZERO;
          w_shift        = 1'b1;
          if (r_bit_cnt == C_LAST_DATA) begin
            w_bit_cnt_next = C_BIT_ZERO;
            w_state_next   = ST_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + C_BIT_ONE;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + C_CLK_ONE;
        end
      end
      ST_STOP: begin
        if (r_clk_cnt == C_BIT_LAST) begin
          w_clk_cnt_next = C_CLK_ZERO;
          if (r_rx_sync) begin
            w_load       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_framing_error = 1'b1;
            w_state_next    = ST_WAIT_IDLE;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + C_CLK_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        // Hold off until the line goes high so a break is not decoded as frames.
        w_clk_cnt_next = C_CLK_ZERO;
        w_bit_cnt_next = C_BIT_ZERO;
        if (r_rx_sync) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT_IDLE;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_clk_cnt_next = C_CLK_ZERO;
        w_bit_cnt_next = C_BIT_ZERO;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_clk_cnt       <= C_CLK_ZERO;
      r_bit_cnt       <= C_BIT_ZERO;
      r_framing_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_clk_cnt       <= w_clk_cnt_next;
      r_bit_cnt       <= w_bit_cnt_next;
      r_framing_error <= w_framing_error;
      // Registered alongside the state, so it always equals (state != IDLE).
      r_busy          <= (w_state_next != ST_IDLE);
    end
  end

  uart_rx_shift_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_shift   (w_shift),
    .i_load    (w_load),
    .i_rx_bit  (r_rx_sync),
    .i_ack     (i_ack),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
  );

  assign o_framing_error = r_framing_error;
  assign o_busy          = r_busy;

endmodule
